clk_pulse_multi: RTL and testbench

//   Multi-channel successor to the single slow-clock pulse generator. Samples CHANNELS

---
 rtl/clk_pulse_pkg.sv | 17 +
 rtl/clk_pulse_multi_if.sv | 24 ++
 rtl/clk_pulse_chan.sv | 103 ++++++++++
 rtl/clk_pulse_multi.sv | 57 +++++
 tb/tb_clk_pulse_multi.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_pulse_pkg.sv
// Shared constants for the multi-channel slow-strobe pulse generator:
// per-channel edge-select encodings and the prime counter sizing helper.
package clk_pulse_pkg;

  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_OFF  = 2'b11
  } edge_mode_e;

  // Must hold SYNC_STAGES+1 (the primed value) without wrapping.
  function automatic int prime_cnt_w(input int sync_stages);
    return $clog2(sync_stages + 2);
  endfunction

endpackage

// File: rtl/clk_pulse_multi_if.sv
// Bundle between the slow-strobe pulse generator and its client logic.
// No handshake: inputs are levels sampled every clk, outputs are registered levels.
interface clk_pulse_multi_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16
);
  logic                      en;
  logic [2*CHANNELS-1:0]     mode;
  logic [CHANNELS-1:0]       slow_in;
  logic [CHANNELS-1:0]       cnt_clr;
  logic [CHANNELS-1:0]       pulse_out;
  logic [CHANNELS*CNT_W-1:0] edge_cnt;
  logic [CHANNELS-1:0]       ovf;

  modport master (
    output en, mode, slow_in, cnt_clr,
    input  pulse_out, edge_cnt, ovf
  );

  modport slave (
    input  en, mode, slow_in, cnt_clr,
    output pulse_out, edge_cnt, ovf
  );
endinterface

// File: rtl/clk_pulse_chan.sv
// One channel: synchroniser, edge select, fixed-width pulse stretcher and
// a wrapping accepted-edge counter with sticky overflow.
module clk_pulse_chan
  import clk_pulse_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_W     = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             primed_i,
  input  logic [1:0]       mode_i,
  input  logic             slow_i,
  input  logic             cnt_clr_i,
  output logic             pulse_o,
  output logic [CNT_W-1:0] edge_cnt_o,
  output logic             ovf_o
);

  localparam int WCW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam logic [WCW-1:0] W_LOAD = WCW'(PULSE_W - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   acc_q;
  logic                   pulse_q, pulse_d;
  logic [WCW-1:0]         wcnt_q, wcnt_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;

  logic s, rise, fall, sel_edge, accepted;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev_q;
  assign fall = ~s & prev_q;

  always_comb begin
    sel_edge = 1'b0;
    case (mode_i)
      MODE_RISE: sel_edge = rise;
      MODE_FALL: sel_edge = fall;
      MODE_BOTH: sel_edge = rise | fall;
      default:   sel_edge = 1'b0;
    endcase
    accepted = sel_edge & en_i & primed_i;
  end

  // acc_q adds the stage that puts the pulse SYNC_STAGES+1 cycles after sampling.
  always_comb begin
    pulse_d = pulse_q;
    wcnt_d  = wcnt_q;
    if (!en_i) begin
      pulse_d = 1'b0;
      wcnt_d  = '0;
    end else if (acc_q && !pulse_q) begin
      pulse_d = 1'b1;
      wcnt_d  = W_LOAD;
    end else if (pulse_q) begin
      if (wcnt_q == '0) pulse_d = 1'b0;
      else              wcnt_d  = wcnt_q - 1'b1;
    end
  end

  // Clear wins over the old value, then the same-cycle edge still counts.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (cnt_clr_i) begin
      cnt_d = accepted ? CNT_W'(1) : '0;
      ovf_d = 1'b0;
    end else if (accepted) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      acc_q   <= 1'b0;
      pulse_q <= 1'b0;
      wcnt_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], slow_i};
      prev_q  <= s;
      acc_q   <= accepted;
      pulse_q <= pulse_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pulse_o    = pulse_q;
  assign edge_cnt_o = cnt_q;
  assign ovf_o      = ovf_q;

endmodule

// File: rtl/clk_pulse_multi.sv
// Multi-channel slow-strobe to clk-domain pulse generator. Holds the shared
// prime counter that masks edges while the synchronisers refill after reset.
module clk_pulse_multi
  import clk_pulse_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_W     = 1,
  parameter int CNT_W       = 16
) (
  input logic               clk,
  input logic               rst_n,
  clk_pulse_multi_if.slave  bus
);

  localparam int PCW = prime_cnt_w(SYNC_STAGES);
  localparam logic [PCW-1:0] PRIME_DONE = PCW'(SYNC_STAGES + 1);

  logic [PCW-1:0] prime_q, prime_d;
  logic           primed;

  assign primed  = (prime_q == PRIME_DONE);
  assign prime_d = primed ? prime_q : prime_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) prime_q <= '0;
    else        prime_q <= prime_d;
  end

  logic [CHANNELS-1:0]       pulse_w;
  logic [CHANNELS-1:0]       ovf_w;
  logic [CHANNELS*CNT_W-1:0] cnt_w;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    clk_pulse_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .PULSE_W     (PULSE_W),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (bus.en),
      .primed_i   (primed),
      .mode_i     (bus.mode[2*g +: 2]),
      .slow_i     (bus.slow_in[g]),
      .cnt_clr_i  (bus.cnt_clr[g]),
      .pulse_o    (pulse_w[g]),
      .edge_cnt_o (cnt_w[g*CNT_W +: CNT_W]),
      .ovf_o      (ovf_w[g])
    );
  end

  assign bus.pulse_out = pulse_w;
  assign bus.edge_cnt  = cnt_w;
  assign bus.ovf       = ovf_w;

endmodule

// File: tb/tb_clk_pulse_multi.sv
// Bench for clk_pulse_multi: two instances (PULSE_W=1/CNT_W=16 and PULSE_W=4/CNT_W=2)
// share stimulus; a cycle model feeds per-instance expected queues, plus directed tables.
module tb_clk_pulse_multi;

  localparam int CH  = 4;
  localparam int SS  = 2;
  localparam int PW0 = 1;
  localparam int CW0 = 16;
  localparam int PW1 = 4;
  localparam int CW1 = 2;
  localparam int W0  = 2*CH + CH*CW0;
  localparam int W1  = 2*CH + CH*CW1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              en_s;
  logic [2*CH-1:0]   mode_s;
  logic [CH-1:0]     slow_s;
  logic [CH-1:0]     clr_s;

  clk_pulse_multi_if #(.CHANNELS(CH), .CNT_W(CW0)) if0 ();
  clk_pulse_multi_if #(.CHANNELS(CH), .CNT_W(CW1)) if1 ();

  assign if0.en = en_s;  assign if0.mode = mode_s;  assign if0.slow_in = slow_s;  assign if0.cnt_clr = clr_s;
  assign if1.en = en_s;  assign if1.mode = mode_s;  assign if1.slow_in = slow_s;  assign if1.cnt_clr = clr_s;

  clk_pulse_multi #(.CHANNELS(CH), .SYNC_STAGES(SS), .PULSE_W(PW0), .CNT_W(CW0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  clk_pulse_multi #(.CHANNELS(CH), .SYNC_STAGES(SS), .PULSE_W(PW1), .CNT_W(CW1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  int vec_cnt  = 0;
  int miss_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- reference model (spec-level, per instance) ----------------
  bit m_h    [2][CH][SS+1];  // m_h[k] = slow_in sample taken k+1 posedges ago
  bit m_pend [2][CH];
  bit m_pulse[2][CH];
  int m_rem  [2][CH];
  int m_cnt  [2][CH];
  bit m_ovf  [2][CH];
  int m_pc   [2];

  task automatic model_step(input int d, input int pw, input int cw);
    bit primed, s, pv, sel, acc;
    int md;
    if (!rst_n) begin
      m_pc[d] = 0;
      for (int ch = 0; ch < CH; ch++) begin
        for (int k = 0; k <= SS; k++) m_h[d][ch][k] = 1'b0;
        m_pend[d][ch] = 0; m_pulse[d][ch] = 0; m_rem[d][ch] = 0;
        m_cnt[d][ch] = 0;  m_ovf[d][ch] = 0;
      end
    end else begin
      primed = (m_pc[d] >= SS + 1);
      for (int ch = 0; ch < CH; ch++) begin
        s  = m_h[d][ch][SS-1];
        pv = m_h[d][ch][SS];
        md = int'(mode_s[2*ch +: 2]);
        case (md)
          0:       sel = s && !pv;
          1:       sel = !s && pv;
          2:       sel = (s != pv);
          default: sel = 1'b0;
        endcase
        acc = sel && en_s && primed;
        if (!en_s) begin
          m_pulse[d][ch] = 0; m_rem[d][ch] = 0;
        end else if (m_pend[d][ch] && !m_pulse[d][ch]) begin
          m_pulse[d][ch] = 1; m_rem[d][ch] = pw;
        end else if (m_pulse[d][ch]) begin
          m_rem[d][ch]--;
          if (m_rem[d][ch] == 0) m_pulse[d][ch] = 0;
        end
        m_pend[d][ch] = acc;
        if (clr_s[ch]) begin
          m_cnt[d][ch] = acc ? 1 : 0;
          m_ovf[d][ch] = 0;
        end else if (acc) begin
          m_cnt[d][ch] = (m_cnt[d][ch] + 1) % (1 << cw);
          if (m_cnt[d][ch] == 0) m_ovf[d][ch] = 1;
        end
        for (int k = SS; k > 0; k--) m_h[d][ch][k] = m_h[d][ch][k-1];
        m_h[d][ch][0] = slow_s[ch];
      end
      if (m_pc[d] < 1000) m_pc[d]++;
    end
  endtask

  logic [W0-1:0] exp_q0[$];
  logic [W1-1:0] exp_q1[$];

  always @(posedge clk) begin
    logic [CH-1:0]     p0, o0, p1, o1;
    logic [CH*CW0-1:0] c0;
    logic [CH*CW1-1:0] c1;
    model_step(0, PW0, CW0);
    model_step(1, PW1, CW1);
    for (int ch = 0; ch < CH; ch++) begin
      p0[ch] = m_pulse[0][ch]; o0[ch] = m_ovf[0][ch]; c0[ch*CW0 +: CW0] = CW0'(m_cnt[0][ch]);
      p1[ch] = m_pulse[1][ch]; o1[ch] = m_ovf[1][ch]; c1[ch*CW1 +: CW1] = CW1'(m_cnt[1][ch]);
    end
    exp_q0.push_back({p0, c0, o0});
    exp_q1.push_back({p1, c1, o1});
  end

  always @(negedge clk) begin
    logic [W0-1:0] e0, a0;
    logic [W1-1:0] e1, a1;
    if (exp_q0.size() > 0) begin
      e0 = exp_q0.pop_front();
      a0 = {if0.pulse_out, if0.edge_cnt, if0.ovf};
      vec_cnt++;
      if (a0 !== e0) begin
        miss_cnt++;
        $display("FAIL sb_dut0 at %0t: got=%h exp=%h", $time, a0, e0);
      end
    end
    if (exp_q1.size() > 0) begin
      e1 = exp_q1.pop_front();
      a1 = {if1.pulse_out, if1.edge_cnt, if1.ovf};
      vec_cnt++;
      if (a1 !== e1) begin
        miss_cnt++;
        $display("FAIL sb_dut1 at %0t: got=%h exp=%h", $time, a1, e1);
      end
    end
  end

  // ---------------- directed table for channel 0 of dut0 ----------------
  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic       slow;
    logic       clr;
    int         cycles;
    int         exp_pulses;
    int         exp_cnt;
    logic       exp_ovf;
  } vec_t;

  vec_t tbl[11];
  int   exp_seq[5];

  initial begin
    int pulses, runs;
    logic last;
    bit did_rst;

    tbl[0]  = '{1'b1, 2'b00, 1'b1, 1'b0, 20, 0, 0, 1'b0};  // high level at release
    tbl[1]  = '{1'b1, 2'b00, 1'b0, 1'b0,  8, 0, 0, 1'b0};  // fall ignored in rise mode
    tbl[2]  = '{1'b1, 2'b00, 1'b1, 1'b0,  8, 1, 1, 1'b0};
    tbl[3]  = '{1'b1, 2'b00, 1'b0, 1'b0,  8, 0, 1, 1'b0};
    tbl[4]  = '{1'b0, 2'b00, 1'b1, 1'b0, 10, 0, 1, 1'b0};  // rise while disabled
    tbl[5]  = '{1'b1, 2'b01, 1'b1, 1'b0,  8, 0, 1, 1'b0};  // re-enable, level unchanged
    tbl[6]  = '{1'b1, 2'b01, 1'b0, 1'b0,  8, 1, 2, 1'b0};
    tbl[7]  = '{1'b1, 2'b10, 1'b1, 1'b0,  8, 1, 3, 1'b0};
    tbl[8]  = '{1'b1, 2'b11, 1'b0, 1'b0,  8, 0, 3, 1'b0};
    tbl[9]  = '{1'b1, 2'b11, 1'b0, 1'b1,  2, 0, 0, 1'b0};
    tbl[10] = '{1'b1, 2'b00, 1'b1, 1'b0,  8, 1, 1, 1'b0};
    exp_seq = '{1, 2, 3, 0, 1};

    en_s   = 1'b1;
    mode_s = '0;
    slow_s = 4'b0001;
    clr_s  = '0;
    rst_n  = 1'b0;
    tick(3);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      en_s        = tbl[i].en;
      mode_s[1:0] = tbl[i].mode;
      slow_s[0]   = tbl[i].slow;
      clr_s[0]    = tbl[i].clr;
      pulses = 0;
      repeat (tbl[i].cycles) begin
        @(negedge clk);
        pulses += int'(if0.pulse_out[0]);
      end
      check($sformatf("tbl%0d_pulses", i), 32'(pulses), 32'(tbl[i].exp_pulses));
      check($sformatf("tbl%0d_cnt", i), 32'(if0.edge_cnt[15:0]), 32'(tbl[i].exp_cnt));
      check($sformatf("tbl%0d_ovf", i), 32'(if0.ovf[0]), 32'(tbl[i].exp_ovf));
    end
    clr_s[0] = 1'b0;

    // Exact latency: sample at posedge t, pulse only at t+3.
    slow_s[0] = 1'b0;
    tick(6);
    slow_s[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("lat_k%0d", k), 32'(if0.pulse_out[0]), 32'(k == 3));
    end
    check("lat_cnt", 32'(if0.edge_cnt[15:0]), 32'd2);

    // Both-mode edges two cycles apart merge into one 4-cycle pulse (dut1 ch1).
    mode_s[3:2] = 2'b10;
    tick(2);
    slow_s[1] = 1'b1;
    tick(2);
    slow_s[1] = 1'b0;
    pulses = 0; runs = 0; last = 1'b0;
    repeat (12) begin
      @(negedge clk);
      pulses += int'(if1.pulse_out[1]);
      if (if1.pulse_out[1] && !last) runs++;
      last = if1.pulse_out[1];
    end
    check("merge_width", 32'(pulses), 32'd4);
    check("merge_runs", 32'(runs), 32'd1);
    check("merge_cnt", 32'(if1.edge_cnt[3:2]), 32'd2);

    // 2-bit counter wrap and sticky overflow (dut1 ch2).
    for (int i = 0; i < 5; i++) begin
      slow_s[2] = 1'b1;
      tick(3);
      check($sformatf("wrap%0d_cnt", i), 32'(if1.edge_cnt[5:4]), 32'(exp_seq[i]));
      check($sformatf("wrap%0d_ovf", i), 32'(if1.ovf[2]), 32'(i >= 3));
      tick(5);
      slow_s[2] = 1'b0;
      tick(8);
    end
    slow_s[2] = 1'b1;
    tick(2);
    clr_s[2] = 1'b1;
    tick(1);
    clr_s[2] = 1'b0;
    check("clr_edge_cnt", 32'(if1.edge_cnt[5:4]), 32'd1);
    check("clr_edge_ovf", 32'(if1.ovf[2]), 32'd0);
    tick(8);

    // Random traffic on all channels with one reset while a pulse is high.
    did_rst = 1'b0;
    for (int c = 0; c < 800; c++) begin
      for (int ch = 0; ch < CH; ch++) begin
        if ($urandom_range(0, 5) == 0) slow_s[ch] = ~slow_s[ch];
        clr_s[ch] = ($urandom_range(0, 49) == 0);
      end
      if (c % 64 == 0) mode_s = 8'($urandom_range(0, 255));
      en_s = ($urandom_range(0, 39) != 0);
      if (!did_rst && c >= 300 && if1.pulse_out != '0) begin
        rst_n = 1'b0;
        tick(1);
        check("midrst_pulse", 32'(if1.pulse_out), 32'd0);
        tick(1);
        rst_n = 1'b1;
        did_rst = 1'b1;
      end
      @(negedge clk);
    end
    check("midrst_seen", 32'(did_rst), 32'd1);

    clr_s = '0;
    tick(4);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
